// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC, single-outstanding imem requests, one-entry decode buffer
//
// Purpose:
//   Holds the program counter. Issues one instruction-memory request at a time.
//   Captures each returned word in a one-entry instruction register.
//   Presents that word to decode through a valid/ready handshake.
//   Supports PC redirect (branch/jump), which also flushes any fetch in flight.
//
// Ports:
//   clk            in   1        clock, all state on rising edge
//   rst_n          in   1        asynchronous active-low reset
//   imem_req       out  1        request strobe (one cycle per request)
//   imem_addr      out  ADDR_W   request address, zero when no request
//   imem_rdata     in   INSTR_W  returned instruction word
//   imem_rvalid    in   1        imem_rdata valid this cycle
//   redirect_valid in   1        load redirect_pc and flush fetch
//   redirect_pc    in   ADDR_W   new PC
//   dec_valid      out  1        decode outputs hold an instruction
//   dec_ready      in   1        decode accepts the held instruction
//   dec_instr      out  INSTR_W  held instruction word
//   dec_opcode     out  4        top nibble of dec_instr, 4'b1111 (NOP) when not valid
//   dec_pc         out  ADDR_W   fetch address of the held instruction

module instr_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [3:0]         dec_opcode,
  output logic [ADDR_W-1:0]  dec_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  // Set when the outstanding request was overtaken by a redirect; its response is dropped.
  logic               discard;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      discard <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
        end
        S_REQ: begin
          state <= S_WAIT;
          // The request leaves with the old pc this cycle, so its answer is stale.
          if (redirect_valid) begin
            pc      <= redirect_pc;
            discard <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (imem_rvalid) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              instr_q <= imem_rdata;
              pc_q    <= pc;
              pc      <= pc + PC_ONE;
              state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end
          if (dec_ready || redirect_valid) begin
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs depend on registered state only; no input reaches them combinationally.
  assign imem_req   = (state == S_REQ);
  assign imem_addr  = (state == S_REQ) ? pc : '0;
  assign dec_valid  = (state == S_HOLD);
  assign dec_instr  = instr_q;
  assign dec_pc     = pc_q;
  assign dec_opcode = dec_valid ? instr_q[INSTR_W-1 -: 4] : 4'b1111;

endmodule
